// File: rtl/icache_nway_burst.sv
// icache_nway_burst: N-way set-associative instruction cache with a two-stage
// lookup pipeline, word-serial burst refill, round-robin replacement and a
// sequential whole-cache invalidate. Stage 1 indexes the synchronous arrays
// with the virtual address; stage 2 compares against the physical tag.
module icache_nway_burst #(
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8,
  parameter int FETCH      = 2,
  parameter int ADDR_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_i,
  input  logic [ADDR_W-1:0]   virtual_addr_i,
  input  logic [ADDR_W-1:0]   physical_addr_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                hit_o,
  output logic [FETCH*32-1:0] inst_o,
  output logic [FETCH-1:0]    inst_valid_o,
  output logic [ADDR_W-1:0]   inst_addr_o,
  output logic                mem_ren_o,
  output logic [ADDR_W-1:0]   mem_araddr_o,
  input  logic                mem_arready_i,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = LINE_WORDS * 32;
  localparam int PL_W   = ADDR_W - OFF_W - 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MISS   = 3'd1,
    REFILL = 3'd2,
    WRITE  = 3'd3,
    RELOOK = 3'd4,
    FLUSH  = 3'd5
  } state_t;

  state_t            state;
  logic              s2_valid;
  logic [ADDR_W-1:0] s2_vaddr;
  logic [PL_W-1:0]   s2_pline;
  logic [OFF_W-1:0]  beat_cnt;
  logic [IDX_W-1:0]  flush_cnt;
  logic              flush_pend;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [PTR_W-1:0]  rr_ptr [SETS];
  logic [31:0]       line_buf [LINE_WORDS];

  logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
  logic [LINE_W-1:0] data_mem [WAYS][SETS];
  logic [TAG_W-1:0]  tag_rd [WAYS];
  logic [LINE_W-1:0] line_rd [WAYS];

  logic [IDX_W-1:0]  s2_idx;
  logic [OFF_W-1:0]  s2_off;
  logic [TAG_W-1:0]  s2_tag;
  logic [IDX_W-1:0]  rd_idx;
  logic [WAYS-1:0]   way_hit;
  logic              any_hit;
  logic              is_idle;
  logic              hit;
  logic              miss;
  logic              flush_enter;
  logic              stall;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] fill_line;
  logic [PTR_W-1:0]  victim;
  logic              use_rr;
  logic [PTR_W-1:0]  rr_next;
  logic              unused_paddr;

  // Only the line-address bits of the physical address are ever needed.
  assign unused_paddr = &{1'b0, physical_addr_i[OFF_W+1:0]};

  assign s2_idx      = s2_vaddr[OFF_W+2 +: IDX_W];
  assign s2_off      = s2_vaddr[2 +: OFF_W];
  assign s2_tag      = s2_pline[PL_W-1 -: TAG_W];
  assign any_hit     = |way_hit;
  assign is_idle     = (state == IDLE);
  assign hit         = s2_valid && any_hit && is_idle;
  assign miss        = s2_valid && !any_hit && is_idle;
  assign flush_enter = is_idle && flush_pend && !miss;
  assign stall       = !is_idle || miss || flush_enter;
  // A stalled pipeline keeps re-reading the held request's set.
  assign rd_idx      = stall ? s2_idx : virtual_addr_i[OFF_W+2 +: IDX_W];

  assign stall_o      = stall;
  assign hit_o        = hit;
  assign inst_addr_o  = s2_vaddr;
  assign mem_ren_o    = (state == MISS);
  assign mem_araddr_o = (state == MISS) ? {s2_pline, {(OFF_W+2){1'b0}}} : {ADDR_W{1'b0}};

  // Per-way tag compare and one-hot selection of the hitting line.
  always_comb begin
    hit_line = {LINE_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[w][s2_idx] && (tag_rd[w] == s2_tag);
      if (way_hit[w]) begin
        hit_line = hit_line | line_rd[w];
      end else begin
        hit_line = hit_line;
      end
    end
  end

  // Fetch slots: slot s returns word offset+s while it stays inside the line.
  always_comb begin
    inst_o       = {(FETCH*32){1'b0}};
    inst_valid_o = {FETCH{1'b0}};
    for (int s = 0; s < FETCH; s++) begin
      logic [OFF_W:0] pos;
      pos = {1'b0, s2_off} + (OFF_W+1)'(s);
      if (hit && (pos < (OFF_W+1)'(LINE_WORDS))) begin
        inst_o[s*32 +: 32] = hit_line[32*pos[OFF_W-1:0] +: 32];
        inst_valid_o[s]    = 1'b1;
      end else begin
        inst_o[s*32 +: 32] = 32'h0000_0000;
        inst_valid_o[s]    = 1'b0;
      end
    end
  end

  // Victim choice: lowest invalid way first, otherwise the set's round-robin pointer.
  always_comb begin
    victim = rr_ptr[s2_idx];
    use_rr = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      if (use_rr && !valid_q[w][s2_idx]) begin
        victim = PTR_W'(w);
        use_rr = 1'b0;
      end else begin
        victim = victim;
      end
    end
    if (rr_ptr[s2_idx] == PTR_W'(WAYS-1)) begin
      rr_next = {PTR_W{1'b0}};
    end else begin
      rr_next = rr_ptr[s2_idx] + PTR_W'(1);
    end
  end

  // Pack the line buffer into one array-width line.
  always_comb begin
    fill_line = {LINE_W{1'b0}};
    for (int i = 0; i < LINE_WORDS; i++) begin
      fill_line[i*32 +: 32] = line_buf[i];
    end
  end

  // Synchronous tag/data arrays: read every cycle, write the refilled line in WRITE.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      tag_rd[w]  <= tag_mem[w][rd_idx];
      line_rd[w] <= data_mem[w][rd_idx];
    end
    if (state == WRITE) begin
      tag_mem[victim][s2_idx]  <= s2_tag;
      data_mem[victim][s2_idx] <= fill_line;
    end
  end

  // Stage-2 registers, flush flag, valid bits, pointers and the control FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s2_valid   <= 1'b0;
      s2_vaddr   <= {ADDR_W{1'b0}};
      s2_pline   <= {PL_W{1'b0}};
      beat_cnt   <= {OFF_W{1'b0}};
      flush_cnt  <= {IDX_W{1'b0}};
      flush_pend <= 1'b0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= {SETS{1'b0}};
      for (int i = 0; i < SETS; i++) rr_ptr[i] <= {PTR_W{1'b0}};
      for (int i = 0; i < LINE_WORDS; i++) line_buf[i] <= 32'h0000_0000;
    end else begin
      if (!stall) begin
        s2_valid <= cpu_req_i;
        if (cpu_req_i) begin
          s2_vaddr <= virtual_addr_i;
          s2_pline <= physical_addr_i[ADDR_W-1:OFF_W+2];
        end
      end else if (flush_enter) begin
        s2_valid <= 1'b0;
      end

      if (flush_enter) begin
        flush_pend <= 1'b0;
      end else if (flush_i && (state != FLUSH)) begin
        flush_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (miss) begin
            state <= MISS;
          end else if (flush_enter) begin
            state     <= FLUSH;
            flush_cnt <= {IDX_W{1'b0}};
          end
        end
        MISS: begin
          if (mem_arready_i) begin
            state    <= REFILL;
            beat_cnt <= {OFF_W{1'b0}};
          end
        end
        REFILL: begin
          if (mem_rvalid_i) begin
            line_buf[beat_cnt] <= mem_rdata_i;
            beat_cnt           <= beat_cnt + OFF_W'(1);
            if (beat_cnt == OFF_W'(LINE_WORDS-1)) begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          valid_q[victim][s2_idx] <= 1'b1;
          if (use_rr) begin
            rr_ptr[s2_idx] <= rr_next;
          end
          state <= RELOOK;
        end
        RELOOK: begin
          state <= IDLE;
        end
        FLUSH: begin
          for (int w = 0; w < WAYS; w++) valid_q[w][flush_cnt] <= 1'b0;
          rr_ptr[flush_cnt] <= {PTR_W{1'b0}};
          flush_cnt         <= flush_cnt + IDX_W'(1);
          if (flush_cnt == IDX_W'(SETS-1)) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_nway_burst.sv
// Directed self-checking bench for icache_nway_burst (default parameters).
module tb_icache_nway_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] vaddr;
  logic [31:0] paddr;
  logic        flush;
  logic        stall;
  logic        hit;
  logic [63:0] inst;
  logic [1:0]  inst_valid;
  logic [31:0] inst_addr;
  logic        mem_ren;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  icache_nway_burst dut (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req), .virtual_addr_i(vaddr),
    .physical_addr_i(paddr), .flush_i(flush), .stall_o(stall), .hit_o(hit),
    .inst_o(inst), .inst_valid_o(inst_valid), .inst_addr_o(inst_addr),
    .mem_ren_o(mem_ren), .mem_araddr_o(araddr), .mem_arready_i(arready),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and play the memory side until the hit (or a reset point).
  task automatic run_req(input logic [31:0] addr, input logic [31:0] base,
                         input int ar_delay, input bit gap, input int flush_at,
                         input int rst_beat, output int hit_cyc, output int ren_cyc,
                         output logic [31:0] ren_addr, output logic hit_stall,
                         output logic [63:0] hit_inst, output logic [1:0] hit_val,
                         output logic [31:0] hit_addr);
    int arw;
    int beat;
    bit in_burst;
    bit phase;
    bit hs;
    bit took;
    arw = 0; beat = 0; in_burst = 1'b0; phase = 1'b0;
    hit_cyc = -1; ren_cyc = -1; ren_addr = 32'h0; hit_stall = 1'b0;
    hit_inst = 64'h0; hit_val = 2'b00; hit_addr = 32'h0;
    cpu_req = 1'b1; vaddr = addr; paddr = addr;
    tick();
    cpu_req = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (hit) begin
        hit_cyc = c; hit_stall = stall; hit_inst = inst; hit_val = inst_valid;
        hit_addr = inst_addr;
        break;
      end
      if ((rst_beat >= 0) && (beat == rst_beat)) begin
        rst = 1'b1;
        #1;
        break;
      end
      if (mem_ren && (ren_cyc < 0)) begin
        ren_cyc = c; ren_addr = araddr;
      end
      arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
      if (in_burst) begin
        rvalid = gap ? phase : 1'b1;
        phase  = !phase;
        rdata  = base + 32'(beat);
      end else if (mem_ren) begin
        if (arw < ar_delay) arw++;
        else arready = 1'b1;
      end
      flush = (c == flush_at);
      hs = arready; took = rvalid;
      tick();
      if (hs) in_burst = 1'b1;
      if (took) beat++;
      if (beat == 8) in_burst = 1'b0;
    end
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; flush = 1'b0;
  endtask

  int          hc, rc, n;
  logic [31:0] ra, ha;
  logic        hs_o;
  logic [63:0] hi;
  logic [1:0]  hv;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; vaddr = 32'h0; paddr = 32'h0; flush = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_hit", 64'(hit), 64'(0));
    check("reset_inst", inst, 64'h0);
    check("reset_valid", 64'(inst_valid), 64'(0));
    check("reset_ren", 64'(mem_ren), 64'(0));
    check("reset_araddr", 64'(araddr), 64'(0));

    // Cold miss on set 0, offset 4.
    run_req(32'h0000_1010, 32'h1000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("cold_ren_cycle", 64'(rc), 64'(1));
    check("cold_araddr", 64'(ra), 64'h0000_1000);
    check("cold_hit_cycle", 64'(hc), 64'(12));
    check("cold_inst", hi, {32'h0000_1005, 32'h0000_1004});
    check("cold_valid", 64'(hv), 64'(2'b11));
    check("cold_stall", 64'(hs_o), 64'(0));
    check("cold_addr", 64'(ha), 64'h0000_1010);

    // Line-edge fetch: last word, upper slot empty.
    run_req(32'h0000_101C, 32'h1000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("edge_hit_cycle", 64'(hc), 64'(0));
    check("edge_valid", 64'(hv), 64'(2'b01));
    check("edge_inst", hi, {32'h0000_0000, 32'h0000_1007});

    // Back-to-back hits, one per cycle.
    cpu_req = 1'b1; vaddr = 32'h0000_1000; paddr = 32'h0000_1000;
    tick();
    vaddr = 32'h0000_1018; paddr = 32'h0000_1018;
    check("b2b0_hit", 64'(hit), 64'(1));
    check("b2b0_inst", inst, {32'h0000_1001, 32'h0000_1000});
    tick();
    cpu_req = 1'b0;
    check("b2b1_hit", 64'(hit), 64'(1));
    check("b2b1_inst", inst, {32'h0000_1007, 32'h0000_1006});
    tick();

    // Replacement in set 0: B fills way 1, C evicts A (pointer 0).
    run_req(32'h0000_2000, 32'h2000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("fillB_hit_cycle", 64'(hc), 64'(12));
    run_req(32'h0000_3000, 32'h3000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("fillC_hit_cycle", 64'(hc), 64'(12));
    check("fillC_inst", hi, {32'h0000_3001, 32'h0000_3000});
    run_req(32'h0000_2000, 32'h2000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("reB_hit_cycle", 64'(hc), 64'(0));
    check("reB_inst", hi, {32'h0000_2001, 32'h0000_2000});
    run_req(32'h0000_3000, 32'h3000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("reC_hit_cycle", 64'(hc), 64'(0));
    run_req(32'h0000_1000, 32'h1000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("reA_ren_cycle", 64'(rc), 64'(1));
    check("reA_hit_cycle", 64'(hc), 64'(12));

    // Throttled burst in set 1: 3 cycles of arready low, rvalid every other cycle.
    run_req(32'h0000_4030, 32'h4000, 3, 1'b1, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("thr_hit_cycle", 64'(hc), 64'(23));
    check("thr_araddr", 64'(ra), 64'h0000_4020);
    check("thr_inst45", hi, {32'h0000_4005, 32'h0000_4004});
    run_req(32'h0000_4020, 32'h4000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("thr_inst01", hi, {32'h0000_4001, 32'h0000_4000});
    run_req(32'h0000_4028, 32'h4000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("thr_inst23", hi, {32'h0000_4003, 32'h0000_4002});
    run_req(32'h0000_4038, 32'h4000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("thr_inst67", hi, {32'h0000_4007, 32'h0000_4006});

    // Flush pulsed during refill: fill completes, hit, then SETS+1 stall cycles.
    run_req(32'h0000_5040, 32'h5000, 0, 1'b0, 4, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("fl_hit_cycle", 64'(hc), 64'(12));
    check("fl_hit_stall", 64'(hs_o), 64'(1));
    check("fl_inst", hi, {32'h0000_5001, 32'h0000_5000});
    n = 0;
    while (stall && (n < 300)) begin
      n++;
      tick();
    end
    check("fl_stall_cycles", 64'(n), 64'(129));
    run_req(32'h0000_5040, 32'h5000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("fl_remiss_ren", 64'(rc), 64'(1));
    check("fl_remiss_hit", 64'(hc), 64'(12));
    run_req(32'h0000_1000, 32'h1000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("fl_set0_miss", 64'(hc), 64'(12));

    // Reset at beat 4 of a refill.
    run_req(32'h0000_6050, 32'h6000, 0, 1'b0, -1, 4, hc, rc, ra, hs_o, hi, hv, ha);
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_hit", 64'(hit), 64'(0));
    check("rst_inst", inst, 64'h0);
    check("rst_valid", 64'(inst_valid), 64'(0));
    check("rst_inst_addr", 64'(inst_addr), 64'(0));
    check("rst_ren", 64'(mem_ren), 64'(0));
    check("rst_araddr", 64'(araddr), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    run_req(32'h0000_6050, 32'h6000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("rst_reburst_ren", 64'(rc), 64'(1));
    check("rst_reburst_addr", 64'(ra), 64'h0000_6040);
    check("rst_reburst_hit", 64'(hc), 64'(12));
    check("rst_reburst_inst", hi, {32'h0000_6005, 32'h0000_6004});
    run_req(32'h0000_1000, 32'h1000, 0, 1'b0, -1, -1, hc, rc, ra, hs_o, hi, hv, ha);
    check("rst_set0_miss", 64'(hc), 64'(12));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
